// File: rtl/mlp_m10k_loader.sv
// Scatters a 75-word weight stream into three 25-deep M10K banks.
// Optional checksum output enabled by MLP_LOADER_CHECKSUM_EN.
module mlp_m10k_loader #(
  parameter int DATA_W     = 27,
  parameter int BANK_DEPTH = 25,
  parameter int NUM_BANKS  = 3,
  localparam int AW = $clog2(BANK_DEPTH),
  localparam int CW = $clog2(BANK_DEPTH * NUM_BANKS),
  localparam int BW = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [AW-1:0]     wr_addr_out,
  output logic [DATA_W-1:0] wr_data,
  output logic              we_m10k0,
  output logic              we_m10k1,
  output logic              we_m10k2,
  output logic              busy,
  output logic              done,
`ifdef MLP_LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [CW-1:0]     load_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] LAST_LCL  = AW'(BANK_DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [NUM_BANKS-1:0] WE_ONE = NUM_BANKS'(1);

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_lcl;
  logic [BW-1:0]         r_bank;
  logic [CW-1:0]         r_cnt;
  logic [AW-1:0]         r_waddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [NUM_BANKS-1:0]  r_we;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_clear;
  logic                  w_ready;
  logic                  w_busy;
  logic                  w_done;

  assign w_acc   = in_valid & (r_state == S_LOAD);
  assign w_last  = (r_bank == LAST_BANK) & (r_lcl == LAST_LCL);
  assign w_clear = (r_state == S_IDLE) & start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake/status decode
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_acc && w_last) w_next = S_FIN;
      end
      S_FIN: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Address walk and registered M10K write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lcl   <= '0;
      r_bank  <= '0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= '0;
    end else begin
      r_we <= '0;
      if (w_clear) begin
        r_lcl  <= '0;
        r_bank <= '0;
        r_cnt  <= '0;
      end
      if (w_acc) begin
        r_wdata <= in_data;
        r_waddr <= r_lcl;
        r_we    <= WE_ONE << r_bank;
        r_cnt   <= r_cnt + CW'(1);
        if (r_lcl == LAST_LCL) begin
          r_lcl  <= '0;
          r_bank <= r_bank + BW'(1);
        end else begin
          r_lcl  <= r_lcl + AW'(1);
        end
      end
    end
  end

`ifdef MLP_LOADER_CHECKSUM_EN
  logic [31:0] r_csum;

  // Running sum of accepted words
  always_ff @(posedge clk) begin
    if (rst)          r_csum <= '0;
    else if (w_clear) r_csum <= '0;
    else if (w_acc)   r_csum <= r_csum + 32'(in_data);
  end

  assign checksum = r_csum;
`endif

  assign in_ready    = w_ready;
  assign busy        = w_busy;
  assign done        = w_done;
  assign wr_addr_out = r_waddr;
  assign wr_data     = r_wdata;
  assign we_m10k0    = r_we[0];
  assign we_m10k1    = r_we[1];
  assign we_m10k2    = r_we[2];
  assign load_count  = r_cnt;

endmodule

// File: tb/tb_mlp_m10k_loader.sv
// Directed bench for mlp_m10k_loader.
// Define MLP_LOADER_CHECKSUM_EN to exercise the checksum port.
module tb_mlp_m10k_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [26:0] in_data;
  logic        in_ready;
  logic [4:0]  wr_addr_out;
  logic [26:0] wr_data;
  logic        we_m10k0;
  logic        we_m10k1;
  logic        we_m10k2;
  logic        busy;
  logic        done;
  logic [6:0]  load_count;
`ifdef MLP_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mlp_m10k_loader dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .wr_addr_out (wr_addr_out),
    .wr_data     (wr_data),
    .we_m10k0    (we_m10k0),
    .we_m10k1    (we_m10k1),
    .we_m10k2    (we_m10k2),
    .busy        (busy),
    .done        (done),
`ifdef MLP_LOADER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .load_count  (load_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] dval(input int mode, input int i);
    if (mode == 1) return 27'(i + 1);
    if (mode == 2) return 27'h7FFFFFF;
    return 27'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: data pattern; gap: toggle valid; poke: start at word 30
  // and in FIN; abort: assert rst when this word is presented
  task automatic do_load(input int mode, input bit gap,
                         input bit poke, input int abort,
                         output logic [31:0] sum);
    int idx;
    int cyc;
    bit acc;
    sum = 0;
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(in_ready), 1);
    chk("start_cnt", 32'(load_count), 0);
    idx = 0;
    cyc = 0;
    while (idx < 75 && cyc < 400) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data  = dval(mode, idx);
      start    = poke && (idx == 30);
      if (idx == abort) begin
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(in_ready), 0);
        chk("abort_cnt", 32'(load_count), 0);
        tick();
        chk("abort_idle_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
        in_valid = 1'b0;
        return;
      end
      acc = in_valid && in_ready;
      tick();
      start = 1'b0;
      if (acc) begin
        sum = sum + 32'(dval(mode, idx));
        chk("we", 32'({we_m10k2, we_m10k1, we_m10k0}),
            32'(3'b001 << (idx / 25)));
        chk("addr", 32'(wr_addr_out), 32'(idx % 25));
        chk("data", 32'(wr_data), 32'(dval(mode, idx)));
        idx++;
      end else begin
        chk("gap_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
      end
      chk("cnt", 32'(load_count), 32'(idx));
      chk("done", 32'(done), 32'(idx == 75));
      cyc++;
    end
    chk("words", 32'(idx), 75);
    chk("fin_ready", 32'(in_ready), 0);
    chk("fin_we2", 32'(we_m10k2), 1);
`ifdef MLP_LOADER_CHECKSUM_EN
    chk("fin_csum", checksum, sum);
`endif
    in_valid = 1'b1;
    start = poke;
    tick();
    start = 1'b0;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
    chk("post_cnt", 32'(load_count), 75);
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ready", 32'(in_ready), 0);
    chk("idle_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
    chk("idle_cnt", 32'(load_count), 75);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 27'h5A5A5A5;

    // T1 reset
    tick();
    tick();
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(wr_addr_out), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_cnt", 32'(load_count), 0);
`ifdef MLP_LOADER_CHECKSUM_EN
    chk("rst_csum", checksum, 0);
`endif
    rst = 1'b0;
    tick();
    chk("idle_vld_we", 32'({we_m10k2, we_m10k1, we_m10k0}), 0);
    chk("idle_vld_ready", 32'(in_ready), 0);
    in_valid = 1'b0;

    // T2 continuous
    do_load(0, 1'b0, 1'b0, -1, s);
    // T3 gapped
    do_load(0, 1'b1, 1'b0, -1, s);
    // T4 stray starts
    do_load(0, 1'b0, 1'b1, -1, s);
    // T5 reset at word 40, then a clean reload
    do_load(0, 1'b0, 1'b0, 40, s);
    do_load(0, 1'b0, 1'b0, -1, s);

`ifdef MLP_LOADER_CHECKSUM_EN
    // T6 checksum
    do_load(1, 1'b0, 1'b0, -1, s);
    chk("csum_seq", checksum, 32'd2850);
    do_load(2, 1'b1, 1'b0, -1, s);
    chk("csum_ones", checksum, 32'h57FFFFB5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
